seq_mult_bcd: RTL and testbench
===============================

SEQ_MULT_BCD -- requirements
Module: seq_mult_bcd

Interface
REQ-001 SHALL provide parameter N, default 8, meaning operand width in bits (N >= 2).
REQ-002 SHALL provide local parameter BCD_W = ((2*N)/3+1)*4, meaning BCD output width.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide port start  input  1  request a new multiplication.
REQ-006 SHALL provide port sgn  input  1  operand mode: 1 = two's complement, 0 = unsigned.
REQ-007 SHALL provide port a_in  input  N  multiplicand.
REQ-008 SHALL provide port b_in  input  N  multiplier.
REQ-009 SHALL provide port out  output  2N  product; two's complement when sgn was 1.
REQ-010 SHALL provide port bcd  output  BCD_W  packed BCD of |product|, least significant digit in bits [3:0].
REQ-011 SHALL provide port bcd_neg  output  1  product is negative.
REQ-012 SHALL provide port busy  output  1  operation in progress.
REQ-013 SHALL provide port finish  output  1  one-cycle result-valid pulse.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, FIX, BCD, DONE; reset state IDLE.
REQ-015 IDLE: start=1 and armed at a rising edge SHALL capture a_in, b_in and sgn, and enter MUL; busy=1 from that edge.
REQ-016 Captured values SHALL be the only operands; input changes while busy SHALL be ignored.
REQ-017 sgn=1: SHALL multiply operand magnitudes (|-2^(N-1)| = 2^(N-1) held in N unsigned bits) and record sign = a[N-1] XOR b[N-1].
REQ-018 MUL: SHALL run radix-2 shift-add, one multiplier bit per cycle, exactly N cycles, then enter FIX.
REQ-019 FIX (1 cycle): SHALL negate the 2N-bit magnitude when sign=1 and the magnitude is nonzero; a zero product SHALL give out=0 and bcd_neg=0.
REQ-020 BCD (present only with the macro, REQ-031): SHALL run shift-and-add-3 double dabble on the 2N-bit magnitude, one bit per cycle, exactly 2N cycles.
REQ-021 DONE (1 cycle): SHALL update out, bcd and bcd_neg, pulse finish=1, clear busy, and return to IDLE.
REQ-022 Latency from the start-accept edge k to the finish edge SHALL be 3N+2 cycles with the macro and N+2 cycles without it.
REQ-023 out, bcd and bcd_neg SHALL hold their last result until the next DONE; intermediate values SHALL never be visible.
REQ-024 Re-arm: after DONE, a new operation SHALL start only after start has been sampled low at least once; a start held high SHALL NOT retrigger.
REQ-025 start asserted while busy SHALL be ignored and SHALL NOT queue.
REQ-026 The product SHALL be exact for all operand values; no overflow is possible in 2N bits.

Reset
REQ-027 reset_n=0 SHALL immediately force state=IDLE, out=0, bcd=0, bcd_neg=0, busy=0, finish=0, armed=1.
REQ-028 Reset mid-operation SHALL abort without producing a finish pulse.
REQ-029 After reset_n rises, a start held high SHALL be accepted at the first rising edge.
REQ-030 Internal datapath registers SHALL reset to 0.

Configuration
REQ-031 Macro SEQ_MULT_BCD_EN defined: SHALL compile in the BCD state and converter; bcd SHALL be valid at finish.
REQ-032 Macro SEQ_MULT_BCD_EN undefined: SHALL omit the BCD state and converter, tie bcd to 0, and skip FIX->BCD (FIX goes directly to DONE); bcd_neg SHALL remain functional.

Verification (N=5, macro defined unless stated)
REQ-033 Unsigned: a_in=26, b_in=30, sgn=0, start pulse -> finish at edge k+17; out=780; bcd=16'h0780; bcd_neg=0.
REQ-034 Signed: a_in=5'b11101 (-3), b_in=7, sgn=1 -> out=10'h3EB (-21); bcd=16'h0021; bcd_neg=1. Also -16 x -16 -> out=10'h100 (256), bcd=16'h0256, bcd_neg=0.
REQ-035 Held start: start held high through two results -> exactly one finish pulse; dropping start for one cycle and raising it again -> second result 13x13: out=169, bcd=16'h0169.
REQ-036 Reset mid-op: reset_n low at cycle 4 of MUL -> all outputs 0 immediately, no finish pulse; the next operation computes correctly.
REQ-037 Operand change: a_in and b_in toggled every cycle while busy -> result equals the captured operands; start pulses while busy -> no extra finish pulse.
REQ-038 Macro undefined: 26x30 -> finish at edge k+7; out=780; bcd=0.

Source files
------------

// File: rtl/seq_mult_bcd.sv
// rtl/seq_mult_bcd.sv - sequential shift-add multiplier with optional BCD result.
// Define SEQ_MULT_BCD_EN to build the double-dabble converter and the BCD state.
module seq_mult_bcd #(
  parameter int N = 8,
  localparam int BCD_W = ((2*N)/3+1)*4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               sgn,
  input  logic [N-1:0]       a_in,
  input  logic [N-1:0]       b_in,
  output logic [2*N-1:0]     out,
  output logic [BCD_W-1:0]   bcd,
  output logic               bcd_neg,
  output logic               busy,
  output logic               finish
);

  localparam int CW = $clog2(2*N+1);

`ifdef SEQ_MULT_BCD_EN
  typedef enum logic [2:0] {IDLE, MUL, FIX, BCD, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, MUL, FIX, DONE} state_t;
`endif

  state_t          state_q;
  logic            armed_q;
  logic            busy_q;
  logic            finish_q;
  logic [2*N-1:0]  out_q;
  logic            bcd_neg_q;
  logic [CW-1:0]   cnt_q;
  logic [2*N-1:0]  acc_q;
  logic [2*N-1:0]  mcand_q;
  logic [N-1:0]    mplier_q;
  logic            sign_q;
  logic [2*N-1:0]  res_q;
  logic            neg_q;
  logic [N-1:0]    a_mag;
  logic [N-1:0]    b_mag;

  // Magnitudes fit in N unsigned bits, including the most negative value.
  assign a_mag = (sgn && a_in[N-1]) ? (~a_in + 1'b1) : a_in;
  assign b_mag = (sgn && b_in[N-1]) ? (~b_in + 1'b1) : b_in;

`ifdef SEQ_MULT_BCD_EN
  logic [BCD_W-1:0] dd_q;
  logic [BCD_W-1:0] bcd_q;
  logic [2*N-1:0]   bin_q;

  function automatic logic [BCD_W-1:0] dd_adj(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_W/4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd = bcd_q;
`else
  assign bcd = '0;
`endif

  assign out     = out_q;
  assign bcd_neg = bcd_neg_q;
  assign busy    = busy_q;
  assign finish  = finish_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b1;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
      out_q     <= '0;
      bcd_neg_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sign_q    <= 1'b0;
      res_q     <= '0;
      neg_q     <= 1'b0;
`ifdef SEQ_MULT_BCD_EN
      dd_q      <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
`endif
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Re-arming only counts while idle, so a start held across DONE never retriggers.
          if (!start) armed_q <= 1'b1;
          if (start && armed_q) begin
            armed_q  <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{N{1'b0}}, a_mag};
            mplier_q <= b_mag;
            sign_q   <= sgn & (a_in[N-1] ^ b_in[N-1]);
            state_q  <= MUL;
          end
        end
        MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) state_q <= FIX;
        end
        FIX: begin
          res_q <= (sign_q && (acc_q != '0)) ? (~acc_q + 1'b1) : acc_q;
          neg_q <= sign_q && (acc_q != '0);
`ifdef SEQ_MULT_BCD_EN
          bin_q   <= acc_q;
          dd_q    <= '0;
          cnt_q   <= '0;
          state_q <= BCD;
`else
          state_q <= DONE;
`endif
        end
`ifdef SEQ_MULT_BCD_EN
        BCD: begin
          {dd_q, bin_q} <= {dd_adj(dd_q), bin_q} << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(2*N-1)) state_q <= DONE;
        end
`endif
        DONE: begin
          out_q     <= res_q;
          bcd_neg_q <= neg_q;
`ifdef SEQ_MULT_BCD_EN
          bcd_q     <= dd_q;
`endif
          finish_q  <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_bcd.sv
// tb/tb_seq_mult_bcd.sv - scoreboard bench for seq_mult_bcd at N=5.
module tb_seq_mult_bcd;
  localparam int N = 5;
`ifdef SEQ_MULT_BCD_EN
  localparam int LAT = 3*N+2;
`else
  localparam int LAT = N+2;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        sgn;
  logic [4:0]  a_in;
  logic [4:0]  b_in;
  logic [9:0]  out;
  logic [15:0] bcd;
  logic        bcd_neg;
  logic        busy;
  logic        finish;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [9:0]  o;
    logic [15:0] b;
    logic        n;
    int          k;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  seq_mult_bcd #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sgn(sgn),
    .a_in(a_in), .b_in(b_in), .out(out), .bcd(bcd),
    .bcd_neg(bcd_neg), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [4:0] a, input logic [4:0] b, input logic s, input int k);
    exp_t e;
    int ia, ib, p, m;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    p = ia * ib;
    m = (p < 0) ? -p : p;
    e.o = 10'(p);
    e.n = (p < 0);
    e.b = '0;
`ifdef SEQ_MULT_BCD_EN
    for (int i = 0; i < 4; i++) begin
      e.b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
`endif
    e.k = k;
    return e;
  endfunction

  always @(negedge clk) begin
    if (finish) begin
      if (q.size() == 0) begin
        chk("unexpected_finish", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("out", 32'(out), 32'(mon_e.o));
        chk("bcd", 32'(bcd), 32'(mon_e.b));
        chk("bcd_neg", 32'(bcd_neg), 32'(mon_e.n));
        chk("latency", 32'(cyc - mon_e.k), 32'(LAT));
        chk("busy_at_finish", 32'(busy), 0);
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic do_op(input logic [4:0] a, input logic [4:0] b, input logic s);
    wait_idle();
    a_in = a; b_in = b; sgn = s; start = 1'b1;
    q.push_back(model(a, b, s, cyc + 1));
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 1);
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out"}, 32'(out), 0);
    chk({tag, "_bcd"}, 32'(bcd), 0);
    chk({tag, "_bcd_neg"}, 32'(bcd_neg), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_finish"}, 32'(finish), 0);
  endtask

  initial begin
    int t;
    reset_n = 1'b0; start = 1'b1; sgn = 1'b0; a_in = 5'd26; b_in = 5'd30;
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    q.push_back(model(5'd26, 5'd30, 1'b0, cyc + 1));
    @(negedge clk);
    chk("held_start_after_reset", 32'(busy), 1);
    start = 1'b0;

    do_op(5'b11101, 5'd7, 1'b1);
    do_op(5'b10000, 5'b10000, 1'b1);
    do_op(5'd0, 5'b10000, 1'b1);
    do_op(5'b10000, 5'd15, 1'b1);
    do_op(5'd31, 5'd31, 1'b0);

    // Held start: one result only, then a drop-and-raise gives 13x13.
    wait_idle();
    a_in = 5'd9; b_in = 5'd11; sgn = 1'b0; start = 1'b1;
    q.push_back(model(5'd9, 5'd11, 1'b0, cyc + 1));
    repeat (2*LAT + 10) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in = 5'd13; b_in = 5'd13; start = 1'b1;
    q.push_back(model(5'd13, 5'd13, 1'b0, cyc + 1));
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of MUL.
    do_op(5'd21, 5'd19, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    void'(q.pop_back());
    #1 check_zero("midop_reset");
    repeat (2) @(negedge clk);
    chk("midop_no_finish", 32'(finish), 0);
    reset_n = 1'b1;
    do_op(5'd26, 5'd30, 1'b0);

    // Inputs and start churning while busy.
    for (int r = 0; r < 3; r++) begin
      do_op(5'($urandom), 5'($urandom), 1'($urandom));
      for (t = 0; t < 100 && busy; t++) begin
        a_in = 5'($urandom); b_in = 5'($urandom); sgn = 1'($urandom); start = 1'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end

    for (int r = 0; r < 16; r++) do_op(5'($urandom), 5'($urandom), 1'($urandom));

    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
